pixel_frame_ctrl: RTL

Frame scheduler and double-buffered pixel store for the 16-LED neopixel string. It holds two 48-byte GRB frame buffers: a host-writable back buffer and a front buffer streamed to the serializer. It starts one serializer frame per frame-period tick and serves the serializer's byte requests from the front buffer. A host swap request takes effect atomically at the next frame start, so a displayed frame never mixes old and new pixel data.

---
 rtl/pixel_frame_ctrl.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/pixel_frame_ctrl.sv
// -----------------------------------------------------------------------------
// pixel_frame_ctrl
//
// Frame scheduler and double-buffered pixel store for a NUM_LEDS neopixel
// string. Two frame buffers of 3*NUM_LEDS GRB bytes are kept in one RAM:
// the back buffer is written by the host, and the front buffer is streamed
// to the serializer byte by byte. A free-running frame timer produces one
// tick every FRAME_PERIOD cycles. Each tick seen while idle and enabled starts
// a serializer frame. A pending host swap is applied on that same edge, so a
// frame in flight never mixes old and new pixel data.
//
// Ports
//   clk_20M      in   system clock, all logic on the rising edge
//   nrst         in   synchronous active-low reset
//   enable       in   allows ticks to start frames
//   wr_en        in   host write strobe into the back buffer
//   wr_addr[5:0] in   byte index (3*p+0 = G, 3*p+1 = R, 3*p+2 = B)
//   wr_data[7:0] in   byte to write
//   swap_req     in   pulse; swap buffers at the next frame start
//   swap_done    out  pulse; the swap was applied
//   frame_start  out  pulse; serializer begins a frame
//   byte_req     in   serializer pulse requesting the next byte
//   byte_data    out  requested byte (0x00 past the end of the frame)
//   byte_valid   out  pulse qualifying byte_data
//   frame_done   in   serializer pulse; frame and its reset gap are complete
//   busy         out  high while a frame is in progress
//   overrun      out  sticky; a tick arrived while a frame was in progress
// -----------------------------------------------------------------------------
module pixel_frame_ctrl #(
    parameter int NUM_LEDS     = 16,
    parameter int FRAME_PERIOD = 400000
) (
    input  logic       clk_20M,
    input  logic       nrst,
    input  logic       enable,
    input  logic       wr_en,
    input  logic [5:0] wr_addr,
    input  logic [7:0] wr_data,
    input  logic       swap_req,
    output logic       swap_done,
    output logic       frame_start,
    input  logic       byte_req,
    output logic [7:0] byte_data,
    output logic       byte_valid,
    input  logic       frame_done,
    output logic       busy,
    output logic       overrun
);

    // -------------------------------------------------------------------------
    // Constants
    // -------------------------------------------------------------------------
    localparam int                 FRAME_BYTES = 3 * NUM_LEDS;
    localparam int                 TIMER_W     = $clog2(FRAME_PERIOD);
    localparam logic [TIMER_W-1:0] TIMER_LAST  = TIMER_W'(FRAME_PERIOD - 1);
    // Byte index is one bit wider than the 6-bit address so that it can hold
    // FRAME_BYTES itself (the "past the end" position) for a 64-byte frame.
    localparam logic [6:0]         FRAME_END   = 7'(FRAME_BYTES);

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_e;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_e             state_q, state_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [6:0]         idx_q, idx_d;
    logic               front_sel_q, front_sel_d;
    logic               pending_q, pending_d;
    logic               frame_start_q, frame_start_d;
    logic               swap_done_q, swap_done_d;
    logic               byte_valid_q, byte_valid_d;
    logic [7:0]         byte_data_q, byte_data_d;
    logic               overrun_q, overrun_d;

    logic               tick;
    logic               wr_ok;

    // Both buffers live in one array; the top address bit selects the buffer.
    logic [7:0]         mem_q [0:127];

    // -------------------------------------------------------------------------
    // Frame timer: free running, independent of state and enable.
    // -------------------------------------------------------------------------
    assign tick = (timer_q == TIMER_LAST);

    always_comb begin
        if (tick) begin
            timer_d = '0;
        end else begin
            timer_d = timer_q + 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Pixel RAM
    // -------------------------------------------------------------------------
    // Writes always target the buffer that is back before this edge; a swap
    // applied on the same edge only affects later writes.
    assign wr_ok = wr_en && ({1'b0, wr_addr} < FRAME_END);

    // NOTE: the RAM has no reset on purpose; clearing it would need a
    // per-word write port and would stop it mapping onto RAM primitives.
    always_ff @(posedge clk_20M) begin
        if (wr_ok) begin
            mem_q[{~front_sel_q, wr_addr}] <= wr_data;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and output logic
    // -------------------------------------------------------------------------
    // NOTE: every signal written here gets its default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        front_sel_d   = front_sel_q;
        pending_d     = pending_q;
        frame_start_d = 1'b0;
        swap_done_d   = 1'b0;
        byte_valid_d  = 1'b0;
        byte_data_d   = 8'h00;
        overrun_d     = overrun_q;

        unique case (state_q)
            IDLE: begin
                // byte_req and frame_done carry no meaning here.
                if (tick && enable) begin
                    state_d       = STREAM;
                    frame_start_d = 1'b1;
                    idx_d         = '0;
                    if (pending_q) begin
                        front_sel_d = ~front_sel_q;
                        pending_d   = 1'b0;
                        swap_done_d = 1'b1;
                    end
                end
            end

            STREAM: begin
                if (byte_req) begin
                    byte_valid_d = 1'b1;
                    // Past the end the serializer receives zero bytes and
                    // the index parks at the end of the frame.
                    if (idx_q < FRAME_END) begin
                        byte_data_d = mem_q[{front_sel_q, idx_q[5:0]}];
                        idx_d       = idx_q + 1'b1;
                    end
                end
                if (frame_done) begin
                    state_d = IDLE;
                end
                // The tick itself is dropped; only the overrun is recorded.
                if (tick) begin
                    overrun_d = 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // Evaluated after a possible swap so that a request arriving on the
        // swap edge stays pending for the following frame.
        if (swap_req) begin
            pending_d = 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before the edge, independent of statement order.
    always_ff @(posedge clk_20M) begin
        if (!nrst) begin
            state_q       <= IDLE;
            timer_q       <= '0;
            idx_q         <= '0;
            front_sel_q   <= 1'b0;
            pending_q     <= 1'b0;
            frame_start_q <= 1'b0;
            swap_done_q   <= 1'b0;
            byte_valid_q  <= 1'b0;
            byte_data_q   <= 8'h00;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            idx_q         <= idx_d;
            front_sel_q   <= front_sel_d;
            pending_q     <= pending_d;
            frame_start_q <= frame_start_d;
            swap_done_q   <= swap_done_d;
            byte_valid_q  <= byte_valid_d;
            byte_data_q   <= byte_data_d;
            overrun_q     <= overrun_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign frame_start = frame_start_q;
    assign swap_done   = swap_done_q;
    assign byte_valid  = byte_valid_q;
    assign byte_data   = byte_data_q;
    assign overrun     = overrun_q;
    // A frame is in progress exactly while the controller is streaming.
    assign busy        = (state_q == STREAM);

endmodule
